// File: rtl/alu_writeback_stage_if.sv
// Decoder / register-file bundle for the ALU writeback stage.
// The stage connects through the slave modport.
interface alu_writeback_stage_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] Read_Reg_Num_1;
    logic [ADDR_W-1:0] Read_Reg_Num_2;
    logic [DATA_W-1:0] Read_Data_1;
    logic [DATA_W-1:0] Read_Data_2;
    logic [ADDR_W-1:0] Write_Reg_Num;
    logic [DATA_W-1:0] Write_Data;
    logic              RegWrite;
    logic              carry;
    logic              zero;

    modport master (
        output instr_valid, opcode, rd, rs1, rs2, imm, Read_Data_1, Read_Data_2,
        input  instr_ready, Read_Reg_Num_1, Read_Reg_Num_2,
               Write_Reg_Num, Write_Data, RegWrite, carry, zero
    );

    modport slave (
        input  instr_valid, opcode, rd, rs1, rs2, imm, Read_Data_1, Read_Data_2,
        output instr_ready, Read_Reg_Num_1, Read_Reg_Num_2,
               Write_Reg_Num, Write_Data, RegWrite, carry, zero
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: single-cycle ALU ops, 8-cycle shift-add MUL,
// registered writeback with writeback-to-operand forwarding.
module alu_writeback_stage #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned MUL_CYCLES = 8
) (
    input logic                  clk,
    input logic                  reset,
    alu_writeback_stage_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic {RUN, MUL} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_LI, OP_MUL
    } op_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [ADDR_W-1:0] mul_rd_q, mul_rd_d;
    logic [ADDR_W-1:0] wr_num_q, wr_num_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              reg_write_q, reg_write_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic [DATA_W-1:0] op_a, op_b, alu_res, acc_step;
    logic              alu_carry, accept;
    op_t               op;

    assign op                 = op_t'(bus.opcode);
    assign bus.instr_ready    = (state_q == RUN) && !reset;
    assign accept             = bus.instr_valid && bus.instr_ready;
    assign bus.Read_Reg_Num_1 = bus.rs1;
    assign bus.Read_Reg_Num_2 = bus.rs2;
    assign bus.Write_Reg_Num  = wr_num_q;
    assign bus.Write_Data     = wr_data_q;
    assign bus.RegWrite       = reg_write_q;
    assign bus.carry          = carry_q;
    assign bus.zero           = zero_q;

    // The register file is written at the end of the writeback cycle, so the
    // pending write always wins over the (possibly stale) read data.
    always_comb begin
        op_a = (reg_write_q && (wr_num_q == bus.rs1)) ? wr_data_q : bus.Read_Data_1;
        op_b = (reg_write_q && (wr_num_q == bus.rs2)) ? wr_data_q : bus.Read_Data_2;
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = carry_q;
        case (op)
            OP_ADD:  {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a < op_b);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[2:0];
            OP_LI:   alu_res = bus.imm;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_rd_d    = mul_rd_q;
        wr_num_d    = wr_num_q;
        wr_data_d   = wr_data_q;
        reg_write_d = 1'b0;
        carry_d     = carry_q;
        zero_d      = zero_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_a_d  = op_a;
                        mul_b_d  = op_b;
                        mul_rd_d = bus.rd;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        wr_num_d    = bus.rd;
                        wr_data_d   = alu_res;
                        reg_write_d = 1'b1;
                        carry_d     = alu_carry;
                        zero_d      = (alu_res == '0);
                    end
                end
            end
            MUL: begin
                acc_d = acc_q + acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    wr_num_d    = mul_rd_q;
                    wr_data_d   = acc_d;
                    reg_write_d = 1'b1;
                    zero_d      = (acc_d == '0);
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_rd_q    <= '0;
            wr_num_q    <= '0;
            wr_data_q   <= '0;
            reg_write_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_rd_q    <= mul_rd_d;
            wr_num_q    <= wr_num_d;
            wr_data_q   <= wr_data_d;
            reg_write_q <= reg_write_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end
endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Execute/writeback stage that drives the 8 x 8-bit register file. It accepts one decoded instruction per cycle over a valid/ready handshake and supplies the register file read addresses. It computes an 8-bit ALU result from the returned read data and writes the result back through a one-cycle writeback register. MUL is iterative over 8 cycles and back-pressures the decoder; a writeback-to-operand forwarding path removes read-after-write hazards.

## Interface
Parameters:
- DATA_W, 8, datapath width; fixed to match register file
- ADDR_W, 3, register address width
- MUL_CYCLES, 8, shift-add iterations for MUL; equals DATA_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  stage can accept an instruction
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 LI, 111 MUL
- rd, rs1, rs2  in  3 each  destination and source register numbers
- imm  in  8  immediate; used only by LI
- Read_Reg_Num_1, Read_Reg_Num_2  out  3  equal to rs1 and rs2; combinational
- Read_Data_1, Read_Data_2  in  8  register file read data
- Write_Reg_Num  out  3  writeback address; registered
- Write_Data  out  8  writeback data; registered
- RegWrite  out  1  write strobe; one cycle per instruction
- carry  out  1  carry/borrow from the last ADD/SUB; registered
- zero  out  1  set when the last written result is 0; registered

## Operation
- Operand A is selected as follows:
  - If RegWrite=1 and Write_Reg_Num==rs1, A = Write_Data (forwarding).
  - Otherwise A = Read_Data_1.
- Operand B is selected the same way using rs2.
- An instruction is accepted at a rising edge when instr_valid and instr_ready are both 1. Operands are sampled at that edge.
- The FSM has two states, RUN and MUL. instr_ready = 1 in RUN and 0 in MUL or during reset.
- In RUN, a non-MUL accept loads the WB register at the same edge:
  - Write_Reg_Num = rd, Write_Data = result, RegWrite = 1.
- In RUN, with no accept at an edge, RegWrite becomes 0.
- A MUL accept does the following at that edge:
  - captures A, B and rd
  - clears the accumulator and cnt
  - moves the FSM to MUL
  - sets RegWrite to 0
- In MUL, each edge does the following:
  - if B[cnt]=1, acc += A << cnt, truncated to 8 bits
  - cnt increments
- At the edge where cnt==7, the final iteration also loads the WB register with acc, RegWrite = 1, and the FSM returns to RUN.
- Results:
  - ADD: {carry, result} = A + B, 9-bit.
  - SUB: result = A - B mod 256; carry = 1 when A < B (borrow).
  - AND, OR, XOR: bitwise.
  - SLL: A << B[2:0].
  - LI: imm.
  - MUL: low 8 bits of A*B.
- Only ADD and SUB update carry; every other opcode holds it. zero updates on every write.
- All 8 registers, including r0, are writable.

## Timing
- Reset (asynchronous assert) clears all outputs and state:
  - RegWrite=0, Write_Reg_Num=0, Write_Data=0, carry=0, zero=0
  - FSM = RUN, cnt=0, acc=0
  - instr_ready=0 while reset is high
- Reset deassertion: instr_ready is 1 in the first cycle after reset falls.
- Reset during MUL aborts the operation. No write occurs and no partial result is retained.
- Non-MUL latency: an instruction accepted at edge E0 has RegWrite high during cycle E0..E1. Throughput is 1 instruction per cycle.
- MUL latency, for an instruction accepted at edge E0:
  - instr_ready is low for cycles E0..E8 (8 cycles)
  - RegWrite is high during E8..E9
  - the next instruction can be accepted at edge E9
- Back-to-back dependency: an instruction accepted at E1 that reads rd of the instruction accepted at E0 gets the forwarded value.
- Forwarding takes priority even when the register file already reflects the write.
- instr_valid is ignored while instr_ready=0. The decoder must hold the instruction stable until it is accepted.
- A MUL with rs1==rs2 squares the operand. A MUL with rd equal to a source is legal, because operands were captured at the accept edge.
- Write_Reg_Num and Write_Data hold their last values while RegWrite=0.

## Test plan
- Reset, then LI r1,0x05; LI r2,0x03; ADD r3,r1,r2 on consecutive cycles:
  - ADD r3 uses forwarded r2 = 0x03
  - writes r3=0x08 with carry=0
  - RegWrite is high for 3 consecutive cycles
- LI r1,0xF0; LI r2,0x20; ADD r4,r1,r2 gives r4=0x10, carry=1, zero=0. A following SUB r5,r2,r2 gives r5=0x00, carry=0, zero=1.
- SUB r6,r2,r1 with r2=0x20, r1=0xF0 gives 0x30 and carry=1. SLL r7,r1,r2 with r2=0x03 gives r1<<3 mod 256.
- MUL r3,r1,r2 with r1=0x0D, r2=0x0B:
  - instr_ready is low for exactly 8 cycles
  - a single RegWrite writes r3=0x8F
  - an ADD r4,r3,r3 held on the inputs throughout is accepted on the next cycle and writes r4=0x1E via forwarding
- MUL 0xFF*0xFF gives 0x01. Asserting reset in the 4th MUL cycle produces no RegWrite. After reset, instr_ready=1, Write_Data=0x00, carry=0.
- instr_valid toggled randomly against a reference model for 1000 instructions: register contents and the flags match the model after each write.
